// File: rtl/pokey_pkg.sv
// Shared POKEY definitions: AUDC register layout used by every audio channel.
package pokey_pkg;

    // AUDC bit positions
    localparam int AUDC_POLY5_N = 7;  // 1 = bypass poly5 gating of the timer pulse
    localparam int AUDC_POLY4   = 6;  // 1 = poly4 source, 0 = poly17 source (when not pure tone)
    localparam int AUDC_PURE    = 5;  // 1 = pure square tone
    localparam int AUDC_VOLONLY = 4;  // 1 = output volume level directly

    typedef logic [7:0] audc_t;

endpackage : pokey_pkg

// File: rtl/pokey_audio_channel.sv
// One POKEY audio channel output stage: distortion select, optional
// high-pass flip-flop and volume-only mode, producing the 4-bit sample
// for the mixer. Poly counters and timers are external and shared.
module pokey_audio_channel
    import pokey_pkg::*;
#(
    parameter audc_t AUDC_RESET = 8'h00,
    parameter bit    OUT_REG    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       audc_we,
    input  logic [7:0] audc_din,
    input  logic       timer_pulse,
    input  logic       poly4_bit,
    input  logic       poly5_bit,
    input  logic       poly17_bit,
    input  logic       hp_enable,
    input  logic       hp_clk,
    input  logic       init,
    output logic       chan_bit,
    output logic [3:0] vol_out
);

    audc_t      audc_q, audc_d;
    logic       tone_q, tone_d;
    logic       hp_q,   hp_d;
    logic       gate;
    logic [3:0] sample;

    // Next-state decode for AUDC, tone and high-pass flip-flops
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        audc_d = audc_q;
        tone_d = tone_q;
        hp_d   = hp_q;
        gate   = audc_q[AUDC_POLY5_N] | poly5_bit;

        if (audc_we) begin
            audc_d = audc_din;
        end

        // Tone decision always uses the AUDC value held before this ce
        if (init) begin
            tone_d = 1'b0;
        end else if (timer_pulse && gate) begin
            if (audc_q[AUDC_PURE]) begin
                tone_d = ~tone_q;
            end else if (audc_q[AUDC_POLY4]) begin
                tone_d = poly4_bit;
            end else begin
                tone_d = poly17_bit;
            end
        end

        // High-pass samples the pre-update tone, so a coincident timer pulse
        // and hp_clk see the old tone value
        if (init || !hp_enable) begin
            hp_d = 1'b0;
        end else if (hp_clk) begin
            hp_d = tone_q;
        end
    end

    // Output bit and volume selection from current state
    always_comb begin
        chan_bit = hp_enable ? (tone_q ^ hp_q) : tone_q;
        if (audc_q[AUDC_VOLONLY]) begin
            sample = audc_q[3:0];
        end else begin
            sample = chan_bit ? audc_q[3:0] : 4'h0;
        end
    end

    // Channel state registers, advanced only on clock-enabled edges
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            audc_q <= AUDC_RESET;
            tone_q <= 1'b0;
            hp_q   <= 1'b0;
        end else if (ce) begin
            audc_q <= audc_d;
            tone_q <= tone_d;
            hp_q   <= hp_d;
        end
    end

    generate
        if (OUT_REG) begin : g_vol_reg
            logic [3:0] vol_q;

            // Registered volume sample, one ce behind the channel state
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vol_q <= 4'h0;
                end else if (ce) begin
                    vol_q <= sample;
                end
            end

            assign vol_out = vol_q;
        end else begin : g_vol_comb
            assign vol_out = sample;
        end
    endgenerate

endmodule : pokey_audio_channel

// File: doc/pokey_audio_channel.md
# pokey_audio_channel

Per-channel POKEY audio output stage. It consumes the channel timer underflow pulse and the shared poly4/poly5/poly17 noise bits, then applies the AUDC distortion select, the optional high-pass flip-flop and the volume-only mode. It produces the 4-bit channel volume sample for the mixer. Four instances sit between the poly counters/timers and the POKEY output mixer.

## Interface
Parameters:
- AUDC_RESET, 8'h00, AUDC register value loaded on reset
- OUT_REG, 1, 1 = vol_out registered (one extra ce of latency); 0 = combinational from state

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; all state advances only on clk edges with ce=1
- audc_we  in  1  AUDC write strobe (qualified by ce)
- audc_din  in  8  AUDC write data
- timer_pulse  in  1  channel timer underflow, one ce wide
- poly4_bit  in  1  4-bit poly output
- poly5_bit  in  1  5-bit poly output
- poly17_bit  in  1  17/9-bit poly output (selection done upstream)
- hp_enable  in  1  AUDCTL high-pass enable for this channel
- hp_clk  in  1  high-pass sample pulse (timer underflow of channel+2), one ce wide
- init  in  1  SKCTL init; holds channel idle
- chan_bit  out  1  post-high-pass square/noise bit (debug/mixer tap)
- vol_out  out  4  channel volume sample

## Operation
State: audc[7:0], tone_ff, hp_ff, optional vol_q[3:0].
- AUDC write: on ce with audc_we=1, audc <= audc_din. The new value takes effect from the next ce.
- Tone update on ce with timer_pulse=1 and init=0, gated by gate = audc[7] | poly5_bit. If gate=0, tone_ff holds. If gate=1:
  - audc[5]=1: tone_ff <= ~tone_ff (pure tone).
  - audc[5]=0, audc[6]=1: tone_ff <= poly4_bit.
  - audc[5]=0, audc[6]=0: tone_ff <= poly17_bit.
- High-pass: on ce with hp_clk=1 and hp_enable=1, hp_ff <= tone_ff. The pre-update tone_ff is used when timer_pulse fires in the same ce.
- While hp_enable=0, hp_ff is held at 0 (cleared on the next ce).
- chan_bit = hp_enable ? (tone_ff ^ hp_ff) : tone_ff.
- Volume: if audc[4]=1 (volume-only), sample = audc[3:0] regardless of chan_bit; else sample = chan_bit ? audc[3:0] : 4'h0.
- init=1: tone_ff and hp_ff cleared on each ce and timer_pulse ignored. audc stays writable, and volume-only output is unaffected.

## Timing
- Reset values: audc=AUDC_RESET, tone_ff=0, hp_ff=0, vol_q=0. Therefore chan_bit=0 and vol_out=0, or AUDC_RESET[3:0] if OUT_REG=0 and AUDC_RESET[4]=1.
- Latency, OUT_REG=1: timer_pulse at ce n -> tone_ff changes after edge n -> vol_out changes after the next ce edge (n+1).
- Latency, OUT_REG=0: vol_out follows tone_ff after edge n.
- AUDC write at ce n: the tone decision at n uses old audc. The volume path reflects the new audc after edge n, plus one ce when OUT_REG=1.
- timer_pulse and hp_clk are pulses. If held high, each ce counts as a separate event.
- Reset mid-operation returns all state to reset values asynchronously. The first post-reset event is evaluated on the next ce.

## Structure
- Shared package pokey_pkg: AUDC bit-index constants (AUDC_POLY5_N=7, AUDC_POLY4=6, AUDC_PURE=5, AUDC_VOLONLY=4) and typedef audc_t (8-bit).
- Single flat module, no sub-modules. The poly counters and timers stay external and are shared across the four instances.

## Test plan
- Pure tone: audc=8'hAF, a timer_pulse every 10 ce -> vol_out alternates 4'hF/4'h0, toggling one ce after each pulse (OUT_REG=1).
- Poly5 gating: audc=8'h2F, poly5_bit=0 on a pulse -> tone_ff holds. The same pulse with poly5_bit=1 -> tone_ff toggles.
- Poly4 select: audc=8'hC8, poly4_bit pattern 1,0,0,1 on successive pulses -> vol_out = 8,0,0,8.
- Volume-only: audc=8'h17 with init=1 and no pulses -> vol_out=4'h7 steady. Write 8'h00 -> vol_out=0 after two ce.
- High-pass: audc=8'hAF, hp_enable=1, hp_clk coincident with every timer_pulse -> chan_bit=1 after each pulse. Drop hp_enable -> plain tone resumes.
- Reset mid-tone: assert reset with tone_ff=1 -> vol_out=0 immediately. Deassert -> audc=AUDC_RESET, and the first pulse toggles tone_ff from 0.
